// File: rtl/dmem_responder_if.sv
// MEM-stage to data-memory request/response bundle.
// Master is the pipeline side, slave is the memory responder.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] writeData;
  logic [31:0] ReadData;
  logic        stall;
  logic        ready;
  logic        err;

  modport master (
    output MemRead, MemWrite, Address, writeData,
    input  ReadData, stall, ready, err
  );

  modport slave (
    input  MemRead, MemWrite, Address, writeData,
    output ReadData, stall, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with fixed access latency.
// Holds the pipeline via stall and pulses ready on completion.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic              r_bad;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_err;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_req;
  logic              w_bad;
  logic              w_last;
  logic              w_take;
  logic              w_unused;

  assign w_req  = bus.MemRead | bus.MemWrite;
  assign w_bad  = (bus.Address[1:0] != 2'b00)
                | (bus.MemRead & bus.MemWrite);
  assign w_take = (r_state == S_IDLE) & w_req;
  assign w_last = (r_state == S_WAIT) & (r_cnt == 4'd1);

  // Upper address bits alias onto the array.
  assign w_unused = ^bus.Address[31:ADDR_W+2];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; DONE ignores the still-held request.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req)  w_next = S_WAIT;
      S_WAIT: if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall is forced low while reset is held.
  always_comb begin
    bus.stall = 1'b0;
    unique case (r_state)
      S_IDLE:  bus.stall = rst & w_req;
      S_WAIT:  bus.stall = rst;
      default: bus.stall = 1'b0;
    endcase
  end

  // Latency counter and operand capture on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
    end else if (w_take) begin
      r_cnt   <= 4'(LATENCY);
      r_idx   <= bus.Address[ADDR_W+1:2];
      r_wdata <= bus.writeData;
      r_wr    <= bus.MemWrite;
      r_bad   <= w_bad;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Completion pulses and load data, registered on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= w_last;
      r_err   <= w_last & r_bad;
      if (w_last && !r_wr && !r_bad)
        r_rdata <= r_mem[r_idx];
    end
  end

  // Array write commits on entry to DONE; reset abandons it.
  always_ff @(posedge clk) begin
    if (rst && w_last && r_wr && !r_bad)
      r_mem[r_idx] <= r_wdata;
  end

  assign bus.ReadData = r_rdata;
  assign bus.ready    = r_ready;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Inputs change 1ns after rising edge; outputs sampled on falling edge.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W  (10),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Address   = 32'd0;
    bus.writeData = 32'd0;
  endtask

  // Starts at rising edge + 1ns of the request cycle.
  task automatic access(input string       tag,
                        input bit          rd,
                        input bit          wr,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input bit          exp_err,
                        input bit          chk_rd,
                        input logic [31:0] exp_rd,
                        input bit          scr);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Address   = a;
    bus.writeData = d;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      check({tag, ".stall"}, {31'd0, bus.stall}, 32'd1);
      if (i == 0)
        check({tag, ".rdy0"}, {31'd0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      if (scr) begin
        bus.Address   = 32'h0000_03FC;
        bus.writeData = ~d;
      end
    end
    @(negedge clk);
    check({tag, ".stall_done"}, {31'd0, bus.stall}, 32'd0);
    check({tag, ".ready"}, {31'd0, bus.ready}, 32'd1);
    check({tag, ".err"}, {31'd0, bus.err}, {31'd0, exp_err});
    if (chk_rd)
      check({tag, ".rdata"}, bus.ReadData, exp_rd);
    @(posedge clk);
    #1;
    idle_in();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_in();
    #2;
    check("rst.stall", {31'd0, bus.stall}, 32'd0);
    check("rst.ready", {31'd0, bus.ready}, 32'd0);
    check("rst.err", {31'd0, bus.err}, 32'd0);
    check("rst.rdata", bus.ReadData, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    access("t1.wr", 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    access("t2.rd", 1, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t2.hold", bus.ReadData, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    access("t3.alias", 1, 0, 32'h1010, 0, 0, 1, 32'hDEADBEEF, 0);

    access("t4.mis", 0, 1, 32'h13, 32'h11111111, 1, 0, 0, 0);
    access("t4.rd", 1, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 0);

    access("t5.init", 0, 1, 32'h20, 32'h55AA55AA, 0, 0, 0, 0);
    access("t5.both", 1, 1, 32'h20, 32'h0BAD0BAD, 1, 1, 32'hDEADBEEF, 0);
    access("t5.rd", 1, 0, 32'h20, 0, 0, 1, 32'h55AA55AA, 0);
    access("t5.misrd", 1, 0, 32'h22, 0, 1, 1, 32'h55AA55AA, 0);

    access("tc.wr", 0, 1, 32'h40, 32'hA5A5F00F, 0, 0, 0, 1);
    access("tc.rd", 1, 0, 32'h40, 0, 0, 1, 32'hA5A5F00F, 1);
    access("tc.b2b", 1, 0, 32'h3FC, 0, 0, 0, 0, 0);

    access("t6.init", 0, 1, 32'h30, 32'h12345678, 0, 0, 0, 0);
    bus.MemWrite  = 1'b1;
    bus.Address   = 32'h30;
    bus.writeData = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6.stall", {31'd0, bus.stall}, 32'd0);
    check("t6.ready", {31'd0, bus.ready}, 32'd0);
    check("t6.err", {31'd0, bus.err}, 32'd0);
    check("t6.rdata", bus.ReadData, 32'd0);
    idle_in();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    access("t6.rd", 1, 0, 32'h30, 0, 0, 1, 32'h12345678, 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t7.stall", {31'd0, bus.stall}, 32'd0);
      check("t7.ready", {31'd0, bus.ready}, 32'd0);
      check("t7.err", {31'd0, bus.err}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage side of the pipeline.
- Accepts one read or write request per access from the MEM stage and models a configurable access latency.
- Holds the pipeline with a stall signal until the access completes, then returns read data with a one-cycle ready pulse.
- Replaces the single-cycle data memory wherever the core needs realistic memory timing.

Parameters:
- ADDR_W, 10, word-address width; array holds 2^ADDR_W 32-bit words.
- LATENCY, 2, number of WAIT cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- MemRead  input  1  read request from the MEM stage; held stable while stall=1.
- MemWrite  input  1  write request from the MEM stage; held stable while stall=1.
- Address  input  32  byte address; word index is Address[ADDR_W+1:2].
- writeData  input  32  store data.
- ReadData  output  32  load data; valid when ready=1, held until the next completed read.
- stall  output  1  freeze IF/ID/EX/MEM pipeline registers.
- ready  output  1  one-cycle pulse when an access completes.
- err  output  1  one-cycle pulse with ready for an illegal request.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, ReadData=0, ready=0, err=0, stall=0. The memory array is not cleared. A pending access is abandoned and its write never commits.
- req = MemRead | MemWrite.
- States:
  - IDLE: if req, capture Address, writeData, op and error flags; load counter=LATENCY; go to WAIT. Otherwise stay.
  - WAIT: decrement counter each cycle; go to DONE when counter reaches 1.
  - DONE: always go to IDLE. Requests on the inputs in DONE are ignored, because they are the same request still held by the pipeline.
- stall (combinational) = (IDLE & req) | WAIT. stall=0 in DONE.
- Timing for a request first seen in cycle 0:
  - stall=1 for cycles 0..LATENCY.
  - ready=1 in cycle LATENCY+1 (DONE).
  - The pipeline advances at the end of the DONE cycle.
  - Back-to-back: a new request may be taken in the IDLE cycle immediately after DONE.
- ready and err are registered outputs; err is asserted only together with ready.
- Write commit: the array write happens on the edge entering DONE, using the captured address and data.
- Read: ReadData is loaded on the edge entering DONE from the captured word index.
- A write then read of the same word in consecutive accesses returns the new data.
- Address and error rules:
  - Upper address bits above ADDR_W+1 are ignored, so addresses alias with wrap-around.
  - Address[1:0] != 0 (misaligned): no array access, ReadData unchanged, err=1 with ready. Normal latency still applies.
  - MemRead & MemWrite both asserted: no array access, err=1 with ready, normal latency.
- Input changes during WAIT do not affect the access in flight, because all operands are captured in IDLE.
- Reset asserted mid-operation: outputs go immediately to reset values. After release, the block starts in IDLE and a still-asserted request is taken as a new access.

Test Plan:
1. LATENCY=2, write 0xDEADBEEF to 0x00000010 in cycle 0 -> stall=1 in cycles 0–2, ready=1 and err=0 in cycle 3, stall=0 in cycle 3.
2. Then read 0x00000010 starting in cycle 4 -> stall=1 in cycles 4–6, ready=1 in cycle 7 with ReadData=0xDEADBEEF. ReadData stays 0xDEADBEEF afterwards with no new read.
3. ADDR_W=10, read 0x00001010 after test 2 -> ReadData=0xDEADBEEF (alias of 0x10).
4. Write 0x11111111 to 0x00000013 -> ready=1 and err=1 after normal latency. A subsequent read of 0x10 still returns 0xDEADBEEF.
5. MemRead=1 and MemWrite=1 at 0x20 -> err=1 with ready, and word 0x20 is unchanged.
6. Write 0xCAFEF00D to 0x30, pulse rst=0 during WAIT -> stall, ready and ReadData drop to 0 immediately. After release with req=0, a read of 0x30 returns its prior contents, not 0xCAFEF00D.
7. No request for 10 cycles -> stall=0, ready=0, err=0 throughout.
